riscv_mc_control: RTL

RISCV_MC_CONTROL -- requirements
Module: riscv_mc_control

---
 rtl/riscv_ctrl_pkg.sv | 44 ++++
 rtl/mem_wait_timer.sv | 35 +++
 rtl/riscv_mc_control.sv | 202 ++++++++++++++++++++
 3 files changed

// File: rtl/riscv_ctrl_pkg.sv
// Shared encodings for the multicycle RISC-V control unit:
// FSM states, opcodes and datapath select codes.
package riscv_ctrl_pkg;

   typedef enum logic [2:0] {
      S_FETCH  = 3'd0,
      S_DECODE = 3'd1,
      S_EXEC   = 3'd2,
      S_MEM    = 3'd3,
      S_WB     = 3'd4,
      S_TRAP   = 3'd5
   } state_t;

   localparam logic [6:0] OP_R      = 7'b0110011;
   localparam logic [6:0] OP_I      = 7'b0010011;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_JAL    = 7'b1101111;

   localparam logic [1:0] PC_PLUS4  = 2'd0;
   localparam logic [1:0] PC_TARGET = 2'd1;

   localparam logic [1:0] ALU_ADD   = 2'd0;
   localparam logic [1:0] ALU_SUB   = 2'd1;
   localparam logic [1:0] ALU_FUNCT = 2'd2;

   localparam logic [1:0] WB_ALU = 2'd0;
   localparam logic [1:0] WB_MEM = 2'd1;
   localparam logic [1:0] WB_PC  = 2'd2;

   localparam logic [1:0] SRC_A_PC  = 2'd0;
   localparam logic [1:0] SRC_A_RS1 = 2'd1;

   localparam logic [1:0] SRC_B_RS2  = 2'd0;
   localparam logic [1:0] SRC_B_FOUR = 2'd1;
   localparam logic [1:0] SRC_B_IMM  = 2'd2;

   function automatic logic is_legal(input logic [6:0] op);
      return op inside {OP_R, OP_I, OP_LOAD,
                        OP_STORE, OP_BRANCH, OP_JAL};
   endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// Counts stalled memory cycles; expired pulses on the
// TIMEOUT-th consecutive stall (never when TIMEOUT is 0).
module mem_wait_timer #(
   parameter int TIMEOUT = 16
) (
   input  logic clock,
   input  logic reset,
   input  logic clear,
   input  logic count,
   output logic expired
);

   generate
      if (TIMEOUT == 0) begin : g_off
         assign expired = 1'b0;
      end else begin : g_on
         localparam int W = $clog2(TIMEOUT + 1);
         logic [W-1:0] cnt;

         // Fires combinationally on the stall that reaches TIMEOUT
         assign expired = count && (cnt == W'(TIMEOUT - 1));

         always_ff @(posedge clock or posedge reset) begin
            if (reset) begin
               cnt <= '0;
            end else if (clear) begin
               cnt <= '0;
            end else if (count && !expired) begin
               cnt <= cnt + 1'b1;
            end
         end
      end
   endgenerate

endmodule

// File: rtl/riscv_mc_control.sv
// Multicycle RISC-V control FSM with memory wait timeout.
// Define RETIRE_CNT_EN to add the 32-bit retired counter.
module riscv_mc_control
   import riscv_ctrl_pkg::*;
#(
   parameter int MEM_TIMEOUT = 16
) (
   input  logic       clock,
   input  logic       reset,
   input  logic [6:0] opcode,
   input  logic [2:0] funct3,
   input  logic       zero,
   input  logic       mem_ready,
   output logic       mem_req,
   output logic       mem_we,
   output logic       iord,
   output logic       ir_write,
   output logic       pc_write,
   output logic       reg_write,
   output logic [1:0] pc_src,
   output logic [1:0] alu_src_a,
   output logic [1:0] alu_src_b,
   output logic [1:0] alu_op,
   output logic [1:0] wb_sel,
   output logic [2:0] state,
   output logic       illegal,
   output logic       bus_error
`ifdef RETIRE_CNT_EN
   ,
   output logic [31:0] retired
`endif
);

   state_t cur_st, nxt_st;

   logic req, we, irw, pcw, rgw;
   logic set_ill, set_bus;
   logic expired;

   logic is_alu, is_mem, is_br, is_jal;
   logic is_load, is_store;

   assign is_alu   = (opcode == OP_R) || (opcode == OP_I);
   assign is_load  = (opcode == OP_LOAD);
   assign is_store = (opcode == OP_STORE);
   assign is_mem   = is_load || is_store;
   assign is_br    = (opcode == OP_BRANCH);
   assign is_jal   = (opcode == OP_JAL);

   mem_wait_timer #(
      .TIMEOUT (MEM_TIMEOUT)
   ) u_timer (
      .clock   (clock),
      .reset   (reset),
      .clear   (!req || mem_ready),
      .count   (req && !mem_ready),
      .expired (expired)
   );

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         cur_st <= S_FETCH;
      end else begin
         cur_st <= nxt_st;
      end
   end

   always_comb begin
      nxt_st    = cur_st;
      req       = 1'b0;
      we        = 1'b0;
      iord      = 1'b0;
      irw       = 1'b0;
      pcw       = 1'b0;
      rgw       = 1'b0;
      pc_src    = PC_PLUS4;
      alu_src_a = SRC_A_PC;
      alu_src_b = SRC_B_FOUR;
      alu_op    = ALU_ADD;
      wb_sel    = WB_ALU;
      set_ill   = 1'b0;
      set_bus   = 1'b0;
      unique case (cur_st)
         S_FETCH: begin
            req = 1'b1;
            if (mem_ready) begin
               irw    = 1'b1;
               pcw    = 1'b1;
               nxt_st = S_DECODE;
            end else if (expired) begin
               set_bus = 1'b1;
               nxt_st  = S_TRAP;
            end
         end
         S_DECODE: begin
            // ALU precomputes PC+imm for branch/jump targets
            alu_src_b = SRC_B_IMM;
            if (is_legal(opcode)) begin
               nxt_st = S_EXEC;
            end else begin
               set_ill = 1'b1;
               nxt_st  = S_TRAP;
            end
         end
         S_EXEC: begin
            unique case (1'b1)
               is_alu: begin
                  alu_src_a = SRC_A_RS1;
                  alu_src_b = (opcode == OP_R) ?
                              SRC_B_RS2 : SRC_B_IMM;
                  alu_op    = ALU_FUNCT;
                  nxt_st    = S_WB;
               end
               is_mem: begin
                  alu_src_a = SRC_A_RS1;
                  alu_src_b = SRC_B_IMM;
                  nxt_st    = S_MEM;
               end
               is_br: begin
                  alu_src_a = SRC_A_RS1;
                  alu_src_b = SRC_B_RS2;
                  alu_op    = ALU_SUB;
                  pc_src    = PC_TARGET;
                  if (funct3 == 3'b000 || funct3 == 3'b001) begin
                     pcw = (funct3 == 3'b000) ? zero : !zero;
                     nxt_st = S_FETCH;
                  end else begin
                     set_ill = 1'b1;
                     nxt_st  = S_TRAP;
                  end
               end
               is_jal: begin
                  pcw    = 1'b1;
                  pc_src = PC_TARGET;
                  rgw    = 1'b1;
                  wb_sel = WB_PC;
                  nxt_st = S_FETCH;
               end
               default: begin
                  set_ill = 1'b1;
                  nxt_st  = S_TRAP;
               end
            endcase
         end
         S_MEM: begin
            req  = 1'b1;
            iord = 1'b1;
            we   = is_store;
            if (mem_ready) begin
               nxt_st = is_store ? S_FETCH : S_WB;
            end else if (expired) begin
               set_bus = 1'b1;
               nxt_st  = S_TRAP;
            end
         end
         S_WB: begin
            rgw    = 1'b1;
            wb_sel = is_load ? WB_MEM : WB_ALU;
            nxt_st = S_FETCH;
         end
         S_TRAP: begin
            nxt_st = S_TRAP;
         end
         default: begin
            nxt_st = S_TRAP;
         end
      endcase
   end

   // No bus or register side effects while reset is held
   assign mem_req   = req && !reset;
   assign mem_we    = we && !reset;
   assign ir_write  = irw && !reset;
   assign pc_write  = pcw && !reset;
   assign reg_write = rgw && !reset;
   assign state     = cur_st;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         illegal   <= 1'b0;
         bus_error <= 1'b0;
      end else begin
         if (set_ill) illegal <= 1'b1;
         if (set_bus) bus_error <= 1'b1;
      end
   end

`ifdef RETIRE_CNT_EN
   logic retire_ev;
   assign retire_ev = (nxt_st == S_FETCH) &&
                      (cur_st inside {S_EXEC, S_MEM, S_WB});

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         retired <= '0;
      end else if (retire_ev) begin
         retired <= retired + 32'd1;
      end
   end
`endif

endmodule
